// File: rtl/countdown_timer_pkg.sv
// Shared state encoding for the countdown timer and its helpers.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides qualified ticks by PRESCALE_MAX+1; stride_o marks the tick that wraps the count.
module tick_prescaler #(
    parameter int unsigned PRESCALE_MAX = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    input  logic tick_i,
    output logic stride_o
);

    localparam int unsigned W = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
    localparam logic [W-1:0] MAX_C = W'(PRESCALE_MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && tick_i) begin
            cnt_d = (cnt_q == MAX_C) ? '0 : cnt_q + 1'b1;
        end
    end

    assign stride_o = enable_i && tick_i && !clear_i && (cnt_q == MAX_C);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause/resume and prescaled ticks.
// Optional COUNTDOWN_TIMER_AUTO_RELOAD_EN: reload from the last LOAD_VALUE on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned PRESCALE_MAX  = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE_IN,
    input  logic                     LOAD,
    input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
    input  logic                     START,
    input  logic                     PAUSE,
    output logic [COUNTER_WIDTH-1:0] COUNT,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     done_q, done_d;
    logic                     busy_q;
    logic                     stride;
    logic                     presc_en;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [COUNTER_WIDTH-1:0] reload_q, reload_d;
`endif

    // A tick coinciding with PAUSE or LOAD must not advance the prescaler.
    assign presc_en = (state_q == ST_RUN) && !PAUSE && !LOAD;

    tick_prescaler #(
        .PRESCALE_MAX(PRESCALE_MAX)
    ) u_prescaler (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .clear_i (LOAD),
        .enable_i(presc_en),
        .tick_i  (ENABLE_IN),
        .stride_o(stride)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (LOAD) begin
            count_d = LOAD_VALUE;
            state_d = ST_IDLE;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload_d = LOAD_VALUE;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START && !PAUSE) begin
                        if (count_q == '0) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (PAUSE) begin
                        state_d = ST_PAUSED;
                    end else if (stride && (count_q != '0)) begin
                        if (count_q == ONE) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_EXPIRED;
                            end
`else
                            count_d = '0;
                            state_d = ST_EXPIRED;
`endif
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (START && !PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    count_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            busy_q  <= is_busy(state_d);
        end
    end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign COUNT = count_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
- REQ-001: Parameter COUNTER_WIDTH, default 8, SHALL set the width of LOAD_VALUE and COUNT.
- REQ-002: Parameter PRESCALE_MAX, default 0, SHALL set the number of ENABLE_IN ticks per decrement minus one (PRESCALE_MAX+1 ticks per decrement).
- REQ-003: CLK  input  1  single clock; all state changes on its rising edge.
- REQ-004: RESET  input  1  asynchronous, active-low reset.
- REQ-005: ENABLE_IN  input  1  one-cycle tick qualifier from the system tick source.
- REQ-006: LOAD  input  1  loads LOAD_VALUE into COUNT and the reload register.
- REQ-007: LOAD_VALUE  input  COUNTER_WIDTH  countdown start value.
- REQ-008: START  input  1  start or resume countdown.
- REQ-009: PAUSE  input  1  suspend countdown.
- REQ-010: COUNT  output  COUNTER_WIDTH  current remaining count, registered.
- REQ-011: BUSY  output  1  high in RUN or PAUSED.
- REQ-012: DONE  output  1  registered one-cycle expiry pulse.

Function
- REQ-013: The block SHALL implement states IDLE, RUN, PAUSED and EXPIRED.
- REQ-014: LOAD SHALL take priority over all other inputs in every state: COUNT and reload register <= LOAD_VALUE, prescaler <= 0, state <= IDLE, DONE <= 0.
- REQ-015: IDLE + START with COUNT != 0 SHALL go to RUN; with COUNT == 0 SHALL go to EXPIRED and pulse DONE for one cycle.
- REQ-016: In RUN, each cycle with ENABLE_IN high SHALL increment the prescaler; when prescaler == PRESCALE_MAX it SHALL wrap to 0 and COUNT SHALL decrement by 1 on that same edge.
- REQ-017: ENABLE_IN low SHALL leave prescaler and COUNT unchanged.
- REQ-018: The decrement taking COUNT from 1 to 0 SHALL, on that same edge, assert DONE for exactly one cycle and move to EXPIRED (DONE and COUNT == 0 visible together).
- REQ-019: COUNT SHALL never underflow; no decrement occurs at 0.
- REQ-020: RUN + PAUSE SHALL go to PAUSED with COUNT and prescaler frozen; PAUSED + START (PAUSE low) SHALL return to RUN, resuming the partial prescale.
- REQ-021: START and PAUSE high together SHALL be treated as PAUSE.
- REQ-022: A tick arriving in the same cycle as PAUSE SHALL be ignored.
- REQ-023: EXPIRED SHALL hold COUNT at 0 and ignore START and PAUSE until LOAD.
- REQ-024: BUSY SHALL be a registered decode of state: high exactly in RUN and PAUSED.

Reset
- REQ-025: RESET low SHALL asynchronously force state IDLE, COUNT 0, prescaler 0, reload register 0, DONE 0, BUSY 0.
- REQ-026: Reset asserted mid-countdown SHALL abort without a DONE pulse; after release the block SHALL wait in IDLE for LOAD.

Configuration
- REQ-027: Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN defined: on the 1->0 expiry edge DONE SHALL pulse, COUNT SHALL load the reload register, and state SHALL remain RUN; if the reload register is 0 the block SHALL go to EXPIRED.
- REQ-028: Macro undefined: expiry SHALL always go to EXPIRED per REQ-018; the reload register MAY be omitted.

Structure
- REQ-029: A shared package countdown_timer_pkg SHALL hold the state encoding (2-bit: IDLE=0, RUN=1, PAUSED=2, EXPIRED=3).
- REQ-030: The prescaler SHALL be a sub-module tick_prescaler (inputs clock, reset, clear, enable, tick; output stride pulse), parameterised by PRESCALE_MAX.

Verification
- REQ-031: Reset, LOAD_VALUE=3, PRESCALE_MAX=0, START, ENABLE_IN high continuously -> COUNT 3,2,1,0 on consecutive cycles; DONE high only in the cycle COUNT==0; BUSY low from then.
- REQ-032: PRESCALE_MAX=3, LOAD_VALUE=2, START, tick every cycle -> COUNT decrements every 4th tick; DONE after 8 ticks.
- REQ-033: LOAD_VALUE=5 running, PAUSE at COUNT=3 for 10 ticks, then START -> COUNT stays 3 while paused, BUSY stays high, countdown resumes from 3.
- REQ-034: LOAD_VALUE=0, START -> DONE one cycle later, state EXPIRED, COUNT 0; further START produces no DONE.
- REQ-035: Mid-countdown RESET low for 1 cycle -> COUNT 0, BUSY 0, no DONE; LOAD while running -> IDLE with new value.
- REQ-036: With COUNTDOWN_TIMER_AUTO_RELOAD_EN, LOAD_VALUE=2, tick every cycle -> DONE every 2 ticks, COUNT sequence 2,1,2,1 (0 never held), BUSY stays high.
